// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    localparam int unsigned BCD_DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_e;

    // ceil(w * log10(2)), using log10(2) ~= 0.30103
    function automatic int unsigned min_digits(input int unsigned w);
        return (w * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/add3.sv
// Double-dabble correction cell: adds 3 to a BCD digit of 5 or more before the next shift.
module add3 (
    input  logic [3:0] num,
    output logic [3:0] modnum
);

    always_comb begin
        modnum = (num >= 4'd5) ? num + 4'd3 : num;
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 converter: one input bit per clock behind a start/busy/done handshake.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int unsigned W      = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [W-1:0]                  bin,
    output logic                          busy,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
    output logic                          overflow
);

    localparam int unsigned BW = BCD_DIGIT_W * DIGITS;
    localparam int unsigned CW = $clog2(W + 1);

    state_e          state_q, state_d;
    logic [W-1:0]    shift_q, shift_d;
    logic [BW-1:0]   scratch_q, scratch_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sticky_q, sticky_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic            ovf_q, ovf_d;
    logic            done_q, done_d;

    logic [BW-1:0]   adj;
    logic [BW+W-1:0] shifted;

    for (genvar i = 0; i < DIGITS; i++) begin : g_add3
        add3 u_add3 (
            .num    (scratch_q[BCD_DIGIT_W*i +: BCD_DIGIT_W]),
            .modnum (adj[BCD_DIGIT_W*i +: BCD_DIGIT_W])
        );
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        sticky_d  = sticky_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        shifted   = {adj, shift_q} << 1;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d   = bin;
                    scratch_d = '0;
                    sticky_d  = 1'b0;
                    cnt_d     = CW'(W);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = shifted[W +: BW];
                shift_d   = shifted[W-1:0];
                // Any bit leaving the top digit means the value needs more digits.
                sticky_d  = sticky_q | adj[BW-1];
                cnt_d     = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                bcd_d   = scratch_q;
                ovf_d   = sticky_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            sticky_q  <= 1'b0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            sticky_q  <= sticky_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign bcd      = bcd_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq at W=16/DIGITS=5, W=6/DIGITS=2 and W=8/DIGITS=2.
module tb_bin2bcd_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic        rst16, start16, busy16, done16, ovf16;
    logic [15:0] bin16;
    logic [19:0] bcd16;

    logic        rst6, start6, busy6, done6, ovf6;
    logic [5:0]  bin6;
    logic [7:0]  bcd6;

    logic        rst8, start8, busy8, done8, ovf8;
    logic [7:0]  bin8;
    logic [7:0]  bcd8;

    bin2bcd_seq #(.W(16), .DIGITS(5)) u_dut16 (
        .clk      (clk),
        .reset    (rst16),
        .start    (start16),
        .bin      (bin16),
        .busy     (busy16),
        .done     (done16),
        .bcd      (bcd16),
        .overflow (ovf16)
    );

    bin2bcd_seq #(.W(6), .DIGITS(2)) u_dut6 (
        .clk      (clk),
        .reset    (rst6),
        .start    (start6),
        .bin      (bin6),
        .busy     (busy6),
        .done     (done6),
        .bcd      (bcd6),
        .overflow (ovf6)
    );

    bin2bcd_seq #(.W(8), .DIGITS(2)) u_dut8 (
        .clk      (clk),
        .reset    (rst8),
        .start    (start8),
        .bin      (bin8),
        .busy     (busy8),
        .done     (done8),
        .bcd      (bcd8),
        .overflow (ovf8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Leaves the caller at the first falling edge after the accepting edge.
    task automatic go16(input logic [15:0] b);
        @(negedge clk);
        start16 = 1'b1;
        bin16   = b;
        @(negedge clk);
        start16 = 1'b0;
    endtask

    // Waits for done; optionally re-asserts start mid-run; checks bcd holds its old value.
    task automatic wait16(input bit inject, input logic [19:0] hold, output int n,
                          output int busyc);
        n     = 0;
        busyc = 0;
        while (!done16 && n < 40) begin
            if (busy16) busyc++;
            if (inject && n == 5) begin
                start16 = 1'b1;
                bin16   = 16'd999;
            end
            if (inject && n == 6) start16 = 1'b0;
            if (n == 8) check("bcd_hold", 32'(bcd16), 32'(hold));
            @(negedge clk);
            n++;
        end
    endtask

    task automatic conv6(input int b);
        int n;
        @(negedge clk);
        start6 = 1'b1;
        bin6   = 6'(b);
        @(negedge clk);
        start6 = 1'b0;
        n = 0;
        while (!done6 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("lat6", 32'(n), 32'd7);
        check("bcd6", 32'(bcd6), 32'(((b / 10) << 4) | (b % 10)));
        check("ovf6", 32'(ovf6), 32'd0);
    endtask

    task automatic conv8(input logic [7:0] b, input logic [7:0] exp_bcd, input logic exp_ovf);
        int n;
        @(negedge clk);
        start8 = 1'b1;
        bin8   = b;
        @(negedge clk);
        start8 = 1'b0;
        n = 0;
        while (!done8 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("lat8", 32'(n), 32'd9);
        check("bcd8", 32'(bcd8), 32'(exp_bcd));
        check("ovf8", 32'(ovf8), 32'(exp_ovf));
    endtask

    initial begin
        int n;
        int busyc;
        bit seen;

        rst16 = 1'b1; rst6 = 1'b1; rst8 = 1'b1;
        start16 = 1'b0; start6 = 1'b0; start8 = 1'b0;
        bin16 = '0; bin6 = '0; bin8 = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy16), 32'd0);
        check("rst_done", 32'(done16), 32'd0);
        check("rst_bcd", 32'(bcd16), 32'd0);
        check("rst_ovf", 32'(ovf16), 32'd0);
        rst16 = 1'b0; rst6 = 1'b0; rst8 = 1'b0;

        go16(16'd0);
        wait16(1'b0, 20'h00000, n, busyc);
        check("lat_zero", 32'(n), 32'd17);
        check("busy_cycles", 32'(busyc), 32'd17);
        check("bcd_zero", 32'(bcd16), 32'h00000);
        check("ovf_zero", 32'(ovf16), 32'd0);
        @(negedge clk);
        check("done_pulse", 32'(done16), 32'd0);

        go16(16'd65535);
        wait16(1'b0, 20'h00000, n, busyc);
        check("lat_max", 32'(n), 32'd17);
        check("bcd_max", 32'(bcd16), 32'h65535);
        check("ovf_max", 32'(ovf16), 32'd0);

        go16(16'd12345);
        wait16(1'b0, 20'h65535, n, busyc);
        check("bcd_12345", 32'(bcd16), 32'h12345);

        // Start while busy is ignored; start on the done cycle is accepted.
        go16(16'd100);
        wait16(1'b1, 20'h12345, n, busyc);
        check("lat_ign", 32'(n), 32'd17);
        check("bcd_ign", 32'(bcd16), 32'h00100);
        start16 = 1'b1;
        bin16   = 16'd999;
        @(negedge clk);
        start16 = 1'b0;
        check("b2b_busy", 32'(busy16), 32'd1);
        wait16(1'b0, 20'h00100, n, busyc);
        check("lat_b2b", 32'(n), 32'd17);
        check("bcd_b2b", 32'(bcd16), 32'h00999);

        // Reset mid-conversion aborts with no done pulse.
        go16(16'd4321);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen = seen | done16;
        end
        rst16 = 1'b1;
        @(negedge clk);
        rst16 = 1'b0;
        check("abort_nodone", 32'(seen | done16), 32'd0);
        check("abort_busy", 32'(busy16), 32'd0);
        check("abort_bcd", 32'(bcd16), 32'd0);
        go16(16'd7);
        wait16(1'b0, 20'h00000, n, busyc);
        check("lat_after_rst", 32'(n), 32'd17);
        check("bcd_after_rst", 32'(bcd16), 32'h00007);

        for (int b = 0; b < 64; b++) begin
            conv6(b);
        end

        conv8(8'd255, 8'h55, 1'b1);
        conv8(8'd99, 8'h99, 1'b0);
        conv8(8'd100, 8'h00, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
